// File: rtl/sha256_pkg.sv
// Shared constants for the SHA-256 block sequencer: sequencer state encoding,
// the message-expansion engine's state codes, and small helpers.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } seq_state_e;

  localparam logic [1:0] EXP_IDLE   = 2'd0;
  localparam logic [1:0] EXP_R0_15  = 2'd1;
  localparam logic [1:0] EXP_R16_63 = 2'd2;
  localparam logic [1:0] EXP_R64    = 2'd3;

  localparam logic [6:0] EXP_FINAL_ROUND = 7'd63;
  localparam int         WORDS_PER_BLOCK = 16;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sha256_word_buffer.sv
// 16 x 32-bit block buffer with a single indexed write port; the whole block
// is presented big-endian with word 0 in the top 32 bits.
module sha256_word_buffer
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [31:0]  wdata,
  output logic [511:0] block
);

  logic [31:0] mem_q [WORDS_PER_BLOCK];
  logic [31:0] mem_d [WORDS_PER_BLOCK];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    block = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++) block[511 - 32*i -: 32] = mem_q[i];
  end

endmodule

// File: rtl/sha256_block_sequencer.sv
// Collects 16 pre-padded words into a block, hands it to the message-expansion
// engine, tracks block position within the message and flags protocol errors.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int unsigned TIMEOUT = 96
) (
  input  logic         CLK,
  input  logic         RST,
  // Upstream handshake: a word transfers on a rising edge where word_valid_in
  // and word_ready_out are both high; word_ready_out is high only in FILL.
  input  logic         word_valid_in,
  input  logic [31:0]  word_in,
  input  logic         word_last_in,
  input  logic         abort_in,
  output logic         word_ready_out,
  input  logic [1:0]   exp_state_in,
  input  logic [6:0]   exp_round_in,
  output logic         start_out,
  output logic [511:0] block_out,
  output logic         first_block_out,
  output logic         last_block_out,
  output logic         block_done_out,
  output logic [15:0]  block_idx_out,
  output logic         err_out,
  output logic [2:0]   dbg_state_out
);

  localparam int unsigned      BW         = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0]    BUSY_LIMIT = BW'(TIMEOUT - 1);

  seq_state_e    state_q, state_d;
  logic [3:0]    word_cnt_q, word_cnt_d;
  logic [15:0]   idx_q, idx_d;
  logic          last_q, last_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic          buf_we;
  logic          exp_final;

  assign exp_final = (exp_state_in == EXP_R64) && (exp_round_in == EXP_FINAL_ROUND);

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    err_d      = err_q;
    start_d    = 1'b0;
    done_d     = 1'b0;
    busy_cnt_d = busy_cnt_q;
    buf_we     = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (abort_in) begin
          word_cnt_d = '0;
          idx_d      = '0;
          last_d     = 1'b0;
        end else if (word_valid_in) begin
          // An early last marker means a malformed message: drop it and restart.
          if (word_last_in && (word_cnt_q != 4'd15)) begin
            err_d      = 1'b1;
            word_cnt_d = '0;
            idx_d      = '0;
          end else begin
            buf_we     = 1'b1;
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == 4'd15) begin
              state_d = ST_ISSUE;
              last_d  = word_last_in;
            end
          end
        end
      end
      ST_ISSUE: begin
        if (abort_in) begin
          state_d    = ST_FILL;
          word_cnt_d = '0;
          idx_d      = '0;
          last_d     = 1'b0;
        end else if (exp_state_in == EXP_IDLE) begin
          start_d    = 1'b1;
          state_d    = ST_BUSY;
          busy_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (abort_in) begin
          state_d = ST_DRAIN;
        end else if (exp_final) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (busy_cnt_q == BUSY_LIMIT) begin
          err_d   = 1'b1;
          state_d = ST_DRAIN;
        end else begin
          busy_cnt_d = busy_cnt_q + BW'(1);
        end
      end
      ST_DONE: begin
        if (abort_in) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FILL;
          idx_d   = last_q ? 16'd0 : sat_inc16(idx_q);
        end
      end
      ST_DRAIN: begin
        // Let the expansion engine finish whatever it holds before refilling.
        if (exp_state_in == EXP_IDLE) begin
          state_d    = ST_FILL;
          word_cnt_d = '0;
          idx_d      = '0;
          last_d     = 1'b0;
          busy_cnt_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_FILL;
      word_cnt_q <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      err_q      <= err_d;
      start_q    <= start_d;
      done_q     <= done_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  sha256_word_buffer u_buf (
    .clk   (CLK),
    .rst_n (RST),
    .we    (buf_we),
    .waddr (word_cnt_q),
    .wdata (word_in),
    .block (block_out)
  );

  assign word_ready_out  = (state_q == ST_FILL);
  assign start_out       = start_q;
  assign block_done_out  = done_q;
  assign block_idx_out   = idx_q;
  assign first_block_out = (idx_q == 16'd0);
  assign last_block_out  = last_q;
  assign err_out         = err_q;
  assign dbg_state_out   = state_q;

endmodule
